// File: rtl/bcd_score_counter.sv
// Two-digit BCD up/down score counter fed by three raw push-buttons.
// Each button is synchronised, debounced and edge-detected; each accepted press steps the count once.
module bcd_score_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit WRAP            = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       at_max,
    output logic       at_min,
    output logic       wrap_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Button lanes: bit 0 = inc, bit 1 = dec, bit 2 = clr.
    logic [2:0]         w_raw;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_st;
    logic [2:0]         r_st_d;
    logic [2:0]         r_pulse;
    logic [2:0][CW-1:0] r_cnt;

    logic       w_inc;
    logic       w_dec;
    logic       w_clr;
    logic [3:0] w_hi_nx;
    logic [3:0] w_lo_nx;
    logic       w_wrap_nx;

    assign w_raw = {btn_clr, btn_dec, btn_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_st    <= '0;
            r_st_d  <= '0;
            r_pulse <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_st_d  <= r_st;
            r_pulse <= r_st & ~r_st_d;
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_st[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_st[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_inc = r_pulse[0];
    assign w_dec = r_pulse[1];
    assign w_clr = r_pulse[2];

    // Clear dominates; simultaneous inc and dec cancel out.
    always_comb begin
        w_hi_nx   = digit_hi;
        w_lo_nx   = digit_lo;
        w_wrap_nx = 1'b0;
        if (w_clr) begin
            w_hi_nx = 4'd0;
            w_lo_nx = 4'd0;
        end else if (w_inc && !w_dec) begin
            if (digit_lo < 4'd9) begin
                w_lo_nx = digit_lo + 4'd1;
            end else if (digit_hi < 4'd9) begin
                w_lo_nx = 4'd0;
                w_hi_nx = digit_hi + 4'd1;
            end else if (WRAP) begin
                w_hi_nx   = 4'd0;
                w_lo_nx   = 4'd0;
                w_wrap_nx = 1'b1;
            end
        end else if (w_dec && !w_inc) begin
            if (digit_lo > 4'd0) begin
                w_lo_nx = digit_lo - 4'd1;
            end else if (digit_hi > 4'd0) begin
                w_lo_nx = 4'd9;
                w_hi_nx = digit_hi - 4'd1;
            end else if (WRAP) begin
                w_hi_nx   = 4'd9;
                w_lo_nx   = 4'd9;
                w_wrap_nx = 1'b1;
            end
        end
    end

    // Flags are registered from the next digits so they line up with the digit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_hi   <= 4'd0;
            digit_lo   <= 4'd0;
            at_max     <= 1'b0;
            at_min     <= 1'b1;
            wrap_pulse <= 1'b0;
        end else begin
            digit_hi   <= w_hi_nx;
            digit_lo   <= w_lo_nx;
            at_max     <= (w_hi_nx == 4'd9) && (w_lo_nx == 4'd9);
            at_min     <= (w_hi_nx == 4'd0) && (w_lo_nx == 4'd0);
            wrap_pulse <= w_wrap_nx;
        end
    end

endmodule
